// File: rtl/fsk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsk_pkg
//  Description : Shared types and constants for the FSK encoder. Holds the
//                frame FSM state type, the frame lengths for the raw and
//                Hamming(15,11) formats, the default timing constants and
//                the Hamming encoder used when FSK_HAMMING_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package fsk_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int FRAME_LEN_HAM = 15;
    localparam int FRAME_LEN_RAW = 11;

    localparam int DEF_BIT_CYCLES   = 64;
    localparam int DEF_F0_HALF      = 8;
    localparam int DEF_F1_HALF      = 4;
    localparam int DEF_CLK_DIV_HALF = 1024;

    // Even-parity Hamming(15,11). Result bit 14 is codeword position 1
    // (sent first), bit 0 is position 15 (sent last).
    function automatic logic [14:0] hamming_encode(input logic [10:0] d);
        logic [15:1] cw;
        cw        = '0;
        cw[3]     = d[0];
        cw[5]     = d[1];
        cw[6]     = d[2];
        cw[7]     = d[3];
        cw[15:9]  = d[10:4];
        cw[1]     = cw[3] ^ cw[5] ^ cw[7] ^ cw[9] ^ cw[11] ^ cw[13] ^ cw[15];
        cw[2]     = cw[3] ^ cw[6] ^ cw[7] ^ cw[10] ^ cw[11] ^ cw[14] ^ cw[15];
        cw[4]     = cw[5] ^ cw[6] ^ cw[7] ^ cw[12] ^ cw[13] ^ cw[14] ^ cw[15];
        cw[8]     = cw[9] ^ cw[10] ^ cw[11] ^ cw[12] ^ cw[13] ^ cw[14] ^ cw[15];
        return {cw[1], cw[2], cw[3], cw[4], cw[5], cw[6], cw[7], cw[8],
                cw[9], cw[10], cw[11], cw[12], cw[13], cw[14], cw[15]};
    endfunction

endpackage : fsk_pkg
`default_nettype wire

// File: rtl/code_sep.sv
`default_nettype none
// ============================================================================
//  Module      : code_sep
//  Description : Frame sequencer. Detects a rising edge of send while idle,
//                latches the data word (Hamming encoded when FSK_HAMMING_EN
//                is defined), then shifts it out MSB-first, one bit every
//                BIT_CYCLES clocks.
//  Macro       : FSK_HAMMING_EN - send 15-bit Hamming codeword instead of
//                the 11 raw bits.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-low reset
//                code       - data word, latched on frame start
//                send       - frame request, rising edge sensitive
//                codeout    - current serial bit (0 when idle)
//                sending    - high for the whole frame
//                bit_start  - a new bit begins on the next cycle
//                frame_done - the frame ends on this clock edge
//  Revision    : 1.0 - initial release
// ============================================================================
module code_sep
    import fsk_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] code,
    input  logic        send,
    output logic        codeout,
    output logic        sending,
    output logic        bit_start,
    output logic        frame_done
);

`ifdef FSK_HAMMING_EN
    localparam int FRAME_LEN = FRAME_LEN_HAM;
`else
    localparam int FRAME_LEN = FRAME_LEN_RAW;
`endif

    localparam int              BW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [BW-1:0]   BIT_LAST = BW'(BIT_CYCLES - 1);
    localparam logic [3:0]      IDX_LAST = 4'(FRAME_LEN - 1);

    state_t         state;
    logic           send_r;
    logic           send_armed;
    logic [14:0]    shreg;
    logic [BW-1:0]  bit_cnt;
    logic [3:0]     bit_idx;
    logic [14:0]    load_word;
    logic           accept;
    logic           bit_end;
    logic           last_bit;

    // Frame is left-aligned so the first bit to send is always bit 14.
`ifdef FSK_HAMMING_EN
    assign load_word = hamming_encode(code);
`else
    assign load_word = {code, 4'b0000};
`endif

    // send_armed blocks the first cycle after reset: that cycle only records
    // the level of send, so a send held high through reset is not an edge.
    assign accept     = (state == IDLE) && send_armed && send && !send_r;
    assign bit_end    = (state == SEND) && (bit_cnt == BIT_LAST);
    assign last_bit   = (bit_idx == IDX_LAST);
    assign bit_start  = accept || (bit_end && !last_bit);
    assign frame_done = bit_end && last_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            send_r     <= 1'b0;
            send_armed <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            codeout    <= 1'b0;
            sending    <= 1'b0;
        end else begin
            // Edges seen while sending are consumed here and never queued.
            send_r     <= send;
            send_armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SEND;
                        codeout <= load_word[14];
                        shreg   <= {load_word[13:0], 1'b0};
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        sending <= 1'b1;
                    end
                end
                SEND: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (last_bit) begin
                            state   <= IDLE;
                            codeout <= 1'b0;
                            sending <= 1'b0;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            codeout <= shreg[14];
                            shreg   <= {shreg[13:0], 1'b0};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : code_sep
`default_nettype wire

// File: rtl/fsk_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : fsk_encoder
//  Description : Serial FSK transmitter. Sends an 11-bit word (or its
//                Hamming(15,11) codeword) as a burst of tones: each bit lasts
//                BIT_CYCLES clocks, a 1 toggles the line every F1_HALF clocks,
//                a 0 every F0_HALF clocks. Also provides a free-running
//                divided clock for the upstream word source.
//  Macro       : FSK_HAMMING_EN - transmit the Hamming(15,11) codeword.
//  Ports       : quickclk - sole clock, rising edge
//                reset    - asynchronous active-low reset
//                code     - 11-bit data word
//                send     - frame request, rising edge sensitive
//                outclk   - quickclk / (2*CLK_DIV_HALF), 50% duty
//                codeout  - current serial bit
//                sending  - high while a frame is in progress
//                fsk_out  - modulated line output
//  Revision    : 1.0 - initial release
// ============================================================================
module fsk_encoder
    import fsk_pkg::*;
#(
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int F0_HALF      = DEF_F0_HALF,
    parameter int F1_HALF      = DEF_F1_HALF,
    parameter int CLK_DIV_HALF = DEF_CLK_DIV_HALF
) (
    input  logic        quickclk,
    input  logic        reset,
    input  logic [10:0] code,
    input  logic        send,
    output logic        outclk,
    output logic        codeout,
    output logic        sending,
    output logic        fsk_out
);

    localparam int              DW       = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
    localparam int              TMAX     = (F0_HALF > F1_HALF) ? F0_HALF : F1_HALF;
    localparam int              TW       = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV_HALF - 1);
    localparam logic [TW-1:0]   F0_LAST  = TW'(F0_HALF - 1);
    localparam logic [TW-1:0]   F1_LAST  = TW'(F1_HALF - 1);

    logic [DW-1:0]  div_cnt;
    logic [TW-1:0]  tone_cnt;
    logic [TW-1:0]  tone_last;
    logic           bit_start;
    logic           frame_done;

    code_sep #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_code_sep (
        .clk        (quickclk),
        .reset      (reset),
        .code       (code),
        .send       (send),
        .codeout    (codeout),
        .sending    (sending),
        .bit_start  (bit_start),
        .frame_done (frame_done)
    );

    // Free-running divider, unaffected by frame activity.
    always_ff @(posedge quickclk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            outclk  <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            outclk  <= ~outclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // codeout is the bit currently on the line, so it selects the tone.
    assign tone_last = codeout ? F1_LAST : F0_LAST;

    // Tone restarts high in the first cycle of every bit.
    always_ff @(posedge quickclk or negedge reset) begin
        if (!reset) begin
            tone_cnt <= '0;
            fsk_out  <= 1'b0;
        end else if (bit_start) begin
            tone_cnt <= '0;
            fsk_out  <= 1'b1;
        end else if (frame_done || !sending) begin
            tone_cnt <= '0;
            fsk_out  <= 1'b0;
        end else if (tone_cnt == tone_last) begin
            tone_cnt <= '0;
            fsk_out  <= ~fsk_out;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

endmodule : fsk_encoder
`default_nettype wire

// File: tb/tb_fsk_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fsk_encoder
//  Description : Self-checking bench for fsk_encoder. Expected frames are
//                built from the codeword rules; expected tones from the bit
//                value and the time within the bit. Honours FSK_HAMMING_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsk_encoder;

    localparam int BIT_CYCLES   = 64;
    localparam int F0_HALF      = 8;
    localparam int F1_HALF      = 4;
    localparam int CLK_DIV_HALF = 1024;
`ifdef FSK_HAMMING_EN
    localparam int NBITS = 15;
`else
    localparam int NBITS = 11;
`endif

    logic        quickclk = 1'b0;
    logic        reset    = 1'b0;
    logic [10:0] code     = '0;
    logic        send     = 1'b0;
    wire         outclk;
    wire         codeout;
    wire         sending;
    wire         fsk_out;

    int checks = 0;
    int fails  = 0;

    always #5 quickclk = ~quickclk;

    fsk_encoder #(
        .BIT_CYCLES   (BIT_CYCLES),
        .F0_HALF      (F0_HALF),
        .F1_HALF      (F1_HALF),
        .CLK_DIV_HALF (CLK_DIV_HALF)
    ) dut (
        .quickclk (quickclk),
        .reset    (reset),
        .code     (code),
        .send     (send),
        .outclk   (outclk),
        .codeout  (codeout),
        .sending  (sending),
        .fsk_out  (fsk_out)
    );

    // Frame bit k (k = 0 sent first) for a given data word.
    function automatic logic [14:0] model_frame(input logic [10:0] c);
        logic [14:0] f;
        logic        cw [16];
        logic        x;
        int          d;
        f = '0;
`ifdef FSK_HAMMING_EN
        d = 0;
        for (int pos = 0; pos < 16; pos++) cw[pos] = 1'b0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = c[d];
                d++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            x = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos & p) != 0) && (pos != p)) x = x ^ cw[pos];
            cw[p] = x;
        end
        for (int k = 0; k < 15; k++) f[k] = cw[k + 1];
`else
        d = 0;
        cw[0] = 1'b0;
        x = 1'b0;
        for (int k = 0; k < 11; k++) f[k] = c[10 - k];
`endif
        return f;
    endfunction

    // Starts a frame and checks it cycle by cycle until sending must fall.
    task automatic run_frame(input logic [10:0] c, input bit hold, input bit mid_edge,
                             input string name);
        logic [14:0] f;
        logic        exp_f;
        int          half, bad_c, bad_f, bad_s;
        logic        got_c, got_f, got_s;
        f = model_frame(c);
        @(negedge quickclk);
        code = c;
        send = 1'b1;
        @(posedge quickclk); #1;
        checks++;
        if (sending !== 1'b1) begin
            fails++;
            $display("FAIL %s start: sending=%b required 1", name, sending);
        end
        for (int b = 0; b < NBITS; b++) begin
            bad_c = 0; bad_f = 0; bad_s = 0;
            got_c = 1'b0; got_f = 1'b0; got_s = 1'b0;
            half = f[b] ? F1_HALF : F0_HALF;
            for (int t = 0; t < BIT_CYCLES; t++) begin
                exp_f = (((t / half) % 2) == 0);
                if (codeout !== f[b]) begin bad_c++; got_c = codeout; end
                if (fsk_out !== exp_f) begin bad_f++; got_f = fsk_out; end
                if (sending !== 1'b1) begin bad_s++; got_s = sending; end
                // The word must already be latched: scramble the input.
                code = 11'($urandom);
                if (!hold && b == 0 && t == 0) send = 1'b0;
                if (mid_edge && b == 3 && t == 0) send = 1'b0;
                if (mid_edge && b == 3 && t == 6) send = 1'b1;
                @(posedge quickclk); #1;
            end
            checks++;
            if (bad_c != 0) begin
                fails++;
                $display("FAIL %s codeout bit %0d: got %b in %0d cycles, required %b",
                         name, b, got_c, bad_c, f[b]);
            end
            checks++;
            if (bad_f != 0) begin
                fails++;
                $display("FAIL %s fsk_out bit %0d: %0d cycles wrong (e.g. %b), required half-period %0d starting high",
                         name, b, bad_f, got_f, half);
            end
            checks++;
            if (bad_s != 0) begin
                fails++;
                $display("FAIL %s sending bit %0d: got %b in %0d cycles, required 1",
                         name, b, got_s, bad_s);
            end
        end
        checks++;
        if ({sending, codeout, fsk_out} !== 3'b000) begin
            fails++;
            $display("FAIL %s end: sending/codeout/fsk_out=%b required 000",
                     name, {sending, codeout, fsk_out});
        end
    endtask

    // Watches n cycles; sending and fsk_out must stay low.
    task automatic expect_quiet(input int n, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (sending !== 1'b0 || fsk_out !== 1'b0) bad++;
            @(posedge quickclk); #1;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: activity in %0d of %0d cycles, required none", name, bad, n);
        end
    endtask

    task automatic test_reset;
        int n;
        reset = 1'b0;
        send  = 1'b0;
        repeat (20) @(posedge quickclk);
        #1;
        checks++;
        if (outclk !== 1'b0) begin fails++; $display("FAIL reset outclk: got %b required 0", outclk); end
        checks++;
        if (codeout !== 1'b0) begin fails++; $display("FAIL reset codeout: got %b required 0", codeout); end
        checks++;
        if (sending !== 1'b0) begin fails++; $display("FAIL reset sending: got %b required 0", sending); end
        checks++;
        if (fsk_out !== 1'b0) begin fails++; $display("FAIL reset fsk_out: got %b required 0", fsk_out); end
        @(negedge quickclk);
        reset = 1'b1;
        n = 0;
        while (outclk !== 1'b1 && n < 3 * CLK_DIV_HALF) begin
            @(posedge quickclk); #1;
            n++;
        end
        checks++;
        if (n != CLK_DIV_HALF) begin
            fails++;
            $display("FAIL outclk first rise: after %0d cycles, required %0d", n, CLK_DIV_HALF);
        end
        n = 0;
        while (outclk !== 1'b0 && n < 3 * CLK_DIV_HALF) begin
            @(posedge quickclk); #1;
            n++;
        end
        checks++;
        if (n != CLK_DIV_HALF) begin
            fails++;
            $display("FAIL outclk high time: %0d cycles, required %0d", n, CLK_DIV_HALF);
        end
    endtask

    task automatic test_directed;
        run_frame(11'h001, 1'b0, 1'b0, "code001");
        run_frame(11'h555, 1'b0, 1'b0, "code555");
        run_frame(11'h7FF, 1'b0, 1'b0, "code7ff");
    endtask

    // Consecutive calls restart send one cycle after sending falls.
    task automatic test_random;
        for (int i = 0; i < 4; i++) run_frame(11'($urandom), 1'b0, 1'b0, "random");
    endtask

    task automatic test_ignore_edge;
        run_frame(11'($urandom), 1'b1, 1'b1, "held_send");
        expect_quiet(300, "no queued frame");
        send = 1'b0;
        @(posedge quickclk); #1;
        run_frame(11'($urandom), 1'b0, 1'b0, "after_held");
    endtask

    task automatic test_reset_mid_frame;
        @(negedge quickclk);
        code = 11'($urandom);
        send = 1'b1;
        repeat (5 * BIT_CYCLES + 10) @(posedge quickclk);
        #1;
        checks++;
        if (sending !== 1'b1) begin
            fails++;
            $display("FAIL midreset precondition: sending=%b required 1", sending);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({outclk, codeout, sending, fsk_out} !== 4'b0000) begin
            fails++;
            $display("FAIL midreset async: outclk/codeout/sending/fsk_out=%b required 0000",
                     {outclk, codeout, sending, fsk_out});
        end
        repeat (10) @(posedge quickclk);
        @(negedge quickclk);
        reset = 1'b1;
        @(posedge quickclk); #1;
        expect_quiet(300, "after reset with send held");
        send = 1'b0;
        @(posedge quickclk); #1;
        run_frame(11'($urandom), 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_edge();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_fsk_encoder
`default_nettype wire

// File: doc/fsk_encoder.md
FSK_ENCODER -- requirements
Module: fsk_encoder

Interface
REQ-001 Parameter BIT_CYCLES, default 64: quickclk cycles per transmitted bit.
REQ-002 Parameter F0_HALF, default 8: half-period in quickclk cycles of the bit-0 tone.
REQ-003 Parameter F1_HALF, default 4: half-period in quickclk cycles of the bit-1 tone.
REQ-004 Parameter CLK_DIV_HALF, default 1024: half-period in quickclk cycles of outclk.
REQ-005 quickclk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 code  input  11  data word to transmit.
REQ-008 send  input  1  request strobe; rising edge starts a frame.
REQ-009 outclk  output  1  divided frame clock for the upstream word source.
REQ-010 codeout  output  1  current serial bit.
REQ-011 sending  output  1  high while a frame is in progress.
REQ-012 fsk_out  output  1  FSK-modulated line output.

Function
REQ-013 outclk SHALL toggle every CLK_DIV_HALF quickclk cycles, giving a 50% duty cycle that is free-running and independent of the frame state.
REQ-014 send SHALL be registered, and a frame SHALL start only on a detected 0->1 transition while IDLE; send edges during SEND SHALL be ignored and not queued.
REQ-015 The FSM SHALL have two states, IDLE and SEND; IDLE->SEND on an accepted edge; SEND->IDLE after the last bit's BIT_CYCLES-th cycle.
REQ-016 On acceptance, code SHALL be latched; sending SHALL be high from the next cycle, and the first bit SHALL start in that same cycle.
REQ-017 Each bit SHALL last exactly BIT_CYCLES cycles, with codeout held constant for that duration.
REQ-018 When the bit is 1, fsk_out SHALL toggle every F1_HALF cycles; when the bit is 0, it SHALL toggle every F0_HALF cycles.
REQ-019 At each bit boundary, the tone counter SHALL restart and fsk_out SHALL start high.
REQ-020 In IDLE: fsk_out=0, codeout=0, sending=0.
REQ-021 A frame SHALL be 15 bits with HAMMING_EN defined, otherwise 11 bits, with no gaps between bits.
REQ-022 A new frame MAY be accepted on the cycle after sending falls.

Reset
REQ-023 Reset low SHALL force outclk=0, codeout=0, sending=0, fsk_out=0, the FSM to IDLE, and all counters and the send edge register to 0, immediately and asynchronously.
REQ-024 Reset mid-frame SHALL abort the frame; after release, no frame SHALL be sent until a new send rising edge.

Configuration
REQ-025 Macro FSK_HAMMING_EN defined: the latched word SHALL be Hamming(15,11) encoded with even parity.
REQ-026 Codeword positions 1..15: parity at 1, 2, 4, 8; code[0..3] at positions 3, 5, 6, 7; code[4..10] at positions 9..15.
REQ-027 Parity at position p SHALL be the XOR of all positions whose index has bit p set.
REQ-028 With FSK_HAMMING_EN defined, transmission SHALL run from position 1 first to position 15 last.
REQ-029 FSK_HAMMING_EN undefined: 11 raw bits SHALL be sent, code[10] first, code[0] last.

Structure
REQ-030 Shared package fsk_pkg SHALL hold the state enum (IDLE, SEND), the frame-length constants (15/11) and the default parameter constants.
REQ-031 One sub-module code_sep SHALL implement the latch, optional Hamming encode, shift and bit timing.
REQ-032 The divider and tone generator SHALL stay in fsk_encoder.

Verification
REQ-033 Reset low for 20 cycles, then released: all outputs 0; outclk first rises CLK_DIV_HALF cycles after release.
REQ-034 With FSK_HAMMING_EN, code=11'h001, send pulse: codeout sequence 1,1,1,0,0,0,0,0,0,0,0,0,0,0,0, each 64 cycles; sending high for 960 cycles.
REQ-035 Same frame: fsk_out period 8 cycles during 1-bits and 16 cycles during 0-bits; high at each bit start.
REQ-036 Without FSK_HAMMING_EN, code=11'h555: codeout sequence 1,0,1,0,...,1 over 11 bits; sending high for 704 cycles.
REQ-037 Send held high through a frame, then a second rising edge mid-frame: exactly one frame is sent; a new edge after sending falls starts a second frame.
REQ-038 Reset asserted at bit 5: outputs 0 immediately; with send held high, nothing is sent after release until send goes 0 then 1.
